// File: rtl/qqspi_arbiter.sv
// qqspi_arbiter: round-robin front end sharing one quad-SPI controller between two masters,
// decoding PSRAM/NOR windows and faulting illegal accesses locally.
module qqspi_arbiter #(
  parameter logic [31:0] NOR_START   = 32'h2000_0000,
  parameter logic [31:0] NOR_END     = 32'h2100_0000,
  parameter logic [31:0] PSRAM_START = 32'h8000_0000,
  parameter logic [31:0] PSRAM_END   = 32'h8080_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_fault_o,
  input  logic        m1_valid_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_fault_o,
  output logic        s_valid_o,
  output logic [22:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  output logic        s_psram_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i
);
  typedef enum logic [1:0] {IDLE, BUSY, FAULT, RESP} state_e;
  state_e state_q, state_d;
  logic gnt_q, gnt_d;
  logic s_valid_q, s_valid_d, s_psram_q, s_psram_d;
  logic [22:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0] s_wstrb_q, s_wstrb_d;
  logic [1:0] ready_q, ready_d, fault_q, fault_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic sel, psram_hit, nor_hit;
  logic [31:0] addr, wdata;
  logic [3:0] wstrb;
  // gnt_q doubles as the last-grant pointer: a tie goes to the other master
  always_comb begin
    sel = (m0_valid_i && m1_valid_i) ? ~gnt_q : m1_valid_i;
    addr = sel ? m1_addr_i : m0_addr_i;
    wdata = sel ? m1_wdata_i : m0_wdata_i;
    wstrb = sel ? m1_wstrb_i : m0_wstrb_i;
    psram_hit = addr >= PSRAM_START && addr < PSRAM_END;
    nor_hit = addr >= NOR_START && addr < NOR_END && wstrb == 4'h0;
    state_d = state_q;
    gnt_d = gnt_q;
    s_valid_d = s_valid_q;
    s_addr_d = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    s_psram_d = s_psram_q;
    ready_d = 2'b00;
    fault_d = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m0_valid_i || m1_valid_i) begin
        gnt_d = sel;
        if (psram_hit || nor_hit) begin
          state_d = BUSY;
          s_valid_d = 1'b1;
          s_addr_d = {1'b0, addr[23:2]};
          s_wdata_d = wdata;
          s_wstrb_d = wstrb;
          s_psram_d = psram_hit;
        end else begin
          state_d = FAULT;
          ready_d[sel] = 1'b1;
          fault_d[sel] = 1'b1;
          rdata_d[sel] = '0;
        end
      end
      BUSY: if (s_ready_i) begin
        state_d = RESP;
        s_valid_d = 1'b0;
        ready_d[gnt_q] = 1'b1;
        rdata_d[gnt_q] = s_rdata_i;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q <= 1'b1;
      s_valid_q <= 1'b0;
      s_addr_q <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      s_psram_q <= 1'b0;
      ready_q <= '0;
      fault_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      s_valid_q <= s_valid_d;
      s_addr_q <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      s_psram_q <= s_psram_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
    end
  end
  assign s_valid_o = s_valid_q;
  assign s_addr_o = s_addr_q;
  assign s_wdata_o = s_wdata_q;
  assign s_wstrb_o = s_wstrb_q;
  assign s_psram_o = s_psram_q;
  assign m0_ready_o = ready_q[0];
  assign m1_ready_o = ready_q[1];
  assign m0_fault_o = fault_q[0];
  assign m1_fault_o = fault_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
endmodule

// File: tb/tb_qqspi_arbiter.sv
// tb_qqspi_arbiter: vector table, multi-cycle corner sequences and random two-master traffic
// checked against a transaction-level memory/arbitration model.
module tb_qqspi_arbiter;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] mv = '0;
  logic [1:0][31:0] ma = '0, mw = '0;
  logic [1:0][3:0] ms = '0;
  wire [1:0] mr, mf;
  wire [1:0][31:0] mrd;
  wire s_valid, s_psram;
  wire [22:0] s_addr;
  wire [31:0] s_wdata;
  wire [3:0] s_wstrb;
  logic s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  int n_checks = 0, n_fail = 0;

  qqspi_arbiter dut (
    .clk(clk), .resetn(resetn),
    .m0_valid_i(mv[0]), .m0_addr_i(ma[0]), .m0_wdata_i(mw[0]), .m0_wstrb_i(ms[0]),
    .m0_ready_o(mr[0]), .m0_rdata_o(mrd[0]), .m0_fault_o(mf[0]),
    .m1_valid_i(mv[1]), .m1_addr_i(ma[1]), .m1_wdata_i(mw[1]), .m1_wstrb_i(ms[1]),
    .m1_ready_o(mr[1]), .m1_rdata_o(mrd[1]), .m1_fault_o(mf[1]),
    .s_valid_o(s_valid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_psram_o(s_psram), .s_ready_i(s_ready), .s_rdata_i(s_rdata)
  );

  function automatic logic [31:0] init_word(input logic [22:0] k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] st);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (st[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction
  function automatic bit legal(input logic [31:0] a, input logic [3:0] st);
    return (a >= 32'h8000_0000 && a < 32'h8080_0000) || (a >= 32'h2000_0000 && a < 32'h2100_0000 && st == 4'h0);
  endfunction
  function automatic logic [22:0] key_of(input logic [31:0] a);
    return {a >= 32'h8000_0000, a[23:2]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller model: answers after ctrl_lat wait cycles; writes echo ~wdata as read data
  typedef struct packed {logic psram; logic [22:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} acc_t;
  acc_t acc_q[$];
  logic [31:0] ctrl_mem [logic [22:0]];
  int ctrl_lat = 0, ctrl_cnt = 0;
  logic [22:0] ck;
  logic [31:0] cold;
  always @(posedge clk) begin
    #2;
    if (!resetn || !s_valid) begin
      s_ready = 1'b0;
      ctrl_cnt = 0;
    end else if (s_ready) s_ready = 1'b0;
    else if (ctrl_cnt < ctrl_lat) ctrl_cnt++;
    else begin
      ck = {s_psram, s_addr[21:0]};
      cold = ctrl_mem.exists(ck) ? ctrl_mem[ck] : init_word(ck);
      s_rdata = s_wstrb == 4'h0 ? cold : ~s_wdata;
      if (s_wstrb != 4'h0) ctrl_mem[ck] = merge(cold, s_wdata, s_wstrb);
      acc_q.push_back({s_psram, s_addr, s_wdata, s_wstrb});
      s_ready = 1'b1;
      ctrl_cnt = 0;
    end
  end

  logic [31:0] ref_mem [logic [22:0]];
  task automatic ref_access(input logic [31:0] a, input logic [31:0] w, input logic [3:0] st,
                            output logic f, output logic [31:0] rd);
    logic [22:0] k;
    logic [31:0] old;
    k = key_of(a);
    f = !legal(a, st);
    old = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    rd = f ? 32'h0 : st == 4'h0 ? old : ~w;
    if (!f && st != 4'h0) ref_mem[k] = merge(old, w, st);
  endtask

  // Called at the negedge where master m shows ready
  task automatic complete(input int m, input string tag);
    logic f;
    logic [31:0] rd, a;
    acc_t e, x;
    a = ma[m];
    ref_access(a, mw[m], ms[m], f, rd);
    check({tag, ".fault"}, mf[m], f);
    check({tag, ".rdata"}, mrd[m], rd);
    check({tag, ".other_ready"}, mr[1-m], 0);
    check({tag, ".s_valid_low"}, s_valid, 0);
    if (f) check({tag, ".no_access"}, acc_q.size(), 0);
    else begin
      check({tag, ".one_access"}, acc_q.size(), 1);
      x = {a >= 32'h8000_0000, 1'b0, a[23:2], mw[m], ms[m]};
      if (acc_q.size() > 0) begin
        e = acc_q.pop_front();
        check({tag, ".access"}, e, x);
      end
    end
  endtask

  typedef struct {
    int m; logic [31:0] a; logic [31:0] w; logic [3:0] st; int lat;
    logic fault; logic [31:0] rd; logic [22:0] saddr; logic psram;
  } vec_t;
  vec_t vt[15];

  task automatic single(input vec_t v, input int idx);
    string t;
    int n;
    t = $sformatf("vec%0d", idx);
    ctrl_lat = v.lat;
    mv[v.m] = 1'b1; ma[v.m] = v.a; mw[v.m] = v.w; ms[v.m] = v.st;
    @(negedge clk);
    if (v.fault) begin
      check({t, ".fault_pulse"}, {mr[v.m], mf[v.m], s_valid}, 3'b110);
      check({t, ".fault_rdata"}, mrd[v.m], 0);
    end else begin
      check({t, ".issue"}, {s_valid, s_psram, s_addr}, {1'b1, v.psram, v.saddr});
      n = 0;
      while (!mr[v.m] && n < 200) begin
        @(negedge clk);
        n++;
      end
      check({t, ".latency"}, n, v.lat + 1);
      check({t, ".resp"}, {mf[v.m], mrd[v.m]}, {1'b0, v.rd});
    end
    complete(v.m, t);
    mv[v.m] = 1'b0;
    @(negedge clk);
    check({t, ".pulse_end_hold"}, {mr[v.m], mrd[v.m]}, {1'b0, v.rd});
  endtask

  task automatic gen(input int m, input bit rnd);
    int k;
    if (!rnd) begin
      ma[m] = m == 1 ? 32'h8000_0004 : 32'h2000_0000;
      mw[m] = '0;
      ms[m] = '0;
    end else begin
      k = $urandom_range(0, 4);
      mw[m] = $urandom;
      ms[m] = (k == 1 || k == 3) ? 4'($urandom_range(1, 15)) : 4'h0;
      ma[m] = k < 2 ? 32'h8000_0000 + 32'($urandom_range(0, 63)) :
              k < 4 ? 32'h2000_0000 + 32'($urandom_range(0, 63)) :
              $urandom_range(0, 1) == 1 ? 32'h8080_0000 : 32'($urandom);
    end
  endtask

  // Both masters re-request as soon as allowed, so completions must alternate
  task automatic run_pair(input int n_each, input bit rnd, input string tag, input int first);
    int left[2];
    int prev, cyc;
    left = '{n_each, n_each};
    prev = -1;
    cyc = 0;
    while ((left[0] > 0 || left[1] > 0 || mv != 2'b00) && cyc < 5000) begin
      for (int m = 0; m < 2; m++) begin
        if (mv[m] && mr[m]) begin
          complete(m, tag);
          if (prev < 0 && first >= 0) check({tag, ".first_grant"}, m, first);
          if (prev >= 0 && mv[1-m]) check({tag, ".alternate"}, m, 1 - prev);
          prev = m;
          mv[m] = 1'b0;
        end else if (!mv[m] && left[m] > 0) begin
          gen(m, rnd);
          mv[m] = 1'b1;
          left[m]--;
        end
      end
      if (rnd) ctrl_lat = $urandom_range(0, 3);
      @(negedge clk);
      cyc++;
    end
    check({tag, ".finished"}, cyc < 5000, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] iw;
    int n;
    bit stable;
    repeat (3) @(negedge clk);
    check("reset.ctl", {s_valid, s_psram, s_wstrb, mr, mf}, 0);
    check("reset.s_addr_wdata", {s_addr, s_wdata}, 0);
    check("reset.rdata", mrd, 0);
    resetn = 1'b1;
    @(negedge clk);

    vt[0]  = '{0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 32'h2152_4110, 23'h4, 1'b1};
    vt[1]  = '{0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, 32'hDEAD_BEEF, 23'h4, 1'b1};
    vt[2]  = '{1, 32'h2000_0000, 32'h1111_1111, 4'hF, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[3]  = '{0, 32'h9000_0000, 32'h0, 4'h0, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[4]  = '{0, 32'h2000_0004, 32'h0, 4'h0, 2, 1'b0, init_word(23'h1), 23'h1, 1'b0};
    vt[5]  = '{1, 32'h807F_FFFC, 32'h1234_5678, 4'h3, 0, 1'b0, 32'hEDCB_A987, 23'h1F_FFFF, 1'b1};
    iw = init_word(23'h5F_FFFF);
    vt[6]  = '{1, 32'h807F_FFFC, 32'h0, 4'h0, 1, 1'b0, {iw[31:16], 16'h5678}, 23'h1F_FFFF, 1'b1};
    vt[7]  = '{0, 32'h8080_0000, 32'h0, 4'h0, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[8]  = '{1, 32'h20FF_FFFC, 32'h0, 4'h0, 0, 1'b0, init_word(23'h3F_FFFF), 23'h3F_FFFF, 1'b0};
    vt[9]  = '{0, 32'h2100_0000, 32'h0, 4'h0, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[10] = '{1, 32'h1FFF_FFFC, 32'h0, 4'h0, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[11] = '{0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    vt[12] = '{1, 32'h8000_0000, 32'h0000_00AA, 4'h1, 0, 1'b0, 32'hFFFF_FF55, 23'h0, 1'b1};
    iw = init_word(23'h40_0000);
    vt[13] = '{0, 32'h8000_0000, 32'h0, 4'h0, 3, 1'b0, {iw[31:8], 8'hAA}, 23'h0, 1'b1};
    vt[14] = '{1, 32'h20FF_FFFC, 32'h5, 4'h1, 0, 1'b1, 32'h0, 23'h0, 1'b0};
    for (int i = 0; i < 15; i++) single(vt[i], i);

    // Reset while m0's access is in flight; m0 was the last grant before reset
    ctrl_lat = 50;
    mv[0] = 1'b1; ma[0] = 32'h8000_0020; mw[0] = '0; ms[0] = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", s_valid, 1);
    resetn = 1'b0;
    mv = '0;
    @(negedge clk);
    check("rst.ctl", {s_valid, s_psram, s_wstrb, mr, mf}, 0);
    check("rst.s_addr_wdata", {s_addr, s_wdata}, 0);
    check("rst.rdata", mrd, 0);
    check("rst.no_access", acc_q.size(), 0);
    resetn = 1'b1;
    ctrl_lat = 1;
    run_pair(2, 1'b0, "tie", 0);

    ctrl_lat = 50;
    mv[0] = 1'b1; ma[0] = 32'h8000_0040; mw[0] = 32'hCAFE_F00D; ms[0] = 4'hC;
    @(negedge clk);
    mv[1] = 1'b1; ma[1] = 32'h8000_0040; mw[1] = '0; ms[1] = '0;
    stable = 1'b1;
    n = 0;
    while (!mr[0] && n < 200) begin
      if ({s_valid, s_psram, s_addr, s_wdata, s_wstrb} != {1'b1, 1'b1, 23'h10, 32'hCAFE_F00D, 4'hC} || mr[1])
        stable = 1'b0;
      @(negedge clk);
      n++;
    end
    check("slow.stable", stable, 1);
    check("slow.latency", n, 51);
    complete(0, "slow.m0");
    mv[0] = 1'b0;
    @(negedge clk);
    check("slow.idle_gap", {s_valid, mr[1]}, 0);
    ctrl_lat = 0;
    @(negedge clk);
    check("slow.m1_grant", {s_valid, s_psram, s_addr}, {1'b1, 1'b1, 23'h10});
    n = 0;
    while (!mr[1] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("slow.m1_latency", n, 1);
    complete(1, "slow.m1");
    mv[1] = 1'b0;
    @(negedge clk);

    run_pair(60, 1'b1, "rand", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qqspi_arbiter.md
# qqspi_arbiter

Two-master arbiter that shares the single quad-SPI controller (PSRAM + NOR flash behind one `qqspi` instance) between the CPU memory port and a second bus master (DMA / video fetch). Decodes each request to PSRAM or NOR and grants round-robin. Registers the command into the controller and returns the read data and handshake to the winning master. Illegal accesses (NOR writes, out-of-range addresses) are answered locally with a fault and never reach the controller.

## Interface
Parameters:
- `NOR_START`, 32'h2000_0000, first byte address of NOR window
- `NOR_END`, 32'h2100_0000, first byte address past NOR window
- `PSRAM_START`, 32'h8000_0000, first byte address of PSRAM window
- `PSRAM_END`, 32'h8080_0000, first byte address past PSRAM window

Ports:
- Reset `resetn`, synchronous, active-low; clock `clk`.
- `clk` in 1: clock
- `resetn` in 1: synchronous active-low reset
- `m0_valid` in 1: CPU request
- `m0_addr` in 32: CPU byte address
- `m0_wdata` in 32: CPU write data
- `m0_wstrb` in 4: CPU byte strobes; 0 means read
- `m0_ready` out 1: one-cycle completion pulse
- `m0_rdata` out 32: read data, valid with `m0_ready`
- `m0_fault` out 1: access fault, valid with `m0_ready`
- `m1_valid`, `m1_addr`, `m1_wdata`, `m1_wstrb`, `m1_ready`, `m1_rdata`, `m1_fault`: same for master 1
- `s_valid` out 1: request to controller
- `s_addr` out 23: word address `{1'b0, addr[23:2]}`
- `s_wdata` out 32: write data to controller
- `s_wstrb` out 4: strobes to controller
- `s_psram` out 1: 1 = PSRAM, 0 = NOR (drives `PSRAM_SPIFLASH`)
- `s_ready` in 1: controller completion
- `s_rdata` in 32: controller read data

## Operation
- States: IDLE, BUSY, FAULT, RESP.
- IDLE: pick a requester among asserted `mX_valid`.
  - If only one is asserted, it wins.
  - If both are asserted, the master not granted last wins.
  - The last-grant pointer updates on every grant.
- Decode for the winner, evaluated in IDLE:
  - PSRAM hit: `PSRAM_START <= addr < PSRAM_END`, any strobes.
  - NOR hit: `NOR_START <= addr < NOR_END` and `wstrb == 0`.
  - Anything else is illegal.
- Legal access:
  - Latch addr/wdata/wstrb/psram into output registers.
  - Assert `s_valid`, go to BUSY.
- Illegal access: go to FAULT.
- BUSY:
  - Hold `s_valid` and all `s_*` outputs stable until `s_ready`.
  - On `s_ready`: capture `s_rdata`, drop `s_valid`, go to RESP.
- FAULT:
  - Pulse the granted `mX_ready` with `mX_fault=1` and `mX_rdata=0`.
  - No controller access. Go to IDLE.
- RESP:
  - Pulse the granted `mX_ready` with the captured rdata and `mX_fault=0`.
  - Go to IDLE.
- `s_valid` is low for at least one cycle (RESP) between consecutive controller accesses, so the controller releases `cen`.
- `mX_rdata` holds its last value except after a fault, where it is 0.
- Ungranted masters see `mX_ready=0`.
- Masters hold `valid` and payload until `ready`, and drop `valid` the cycle after `ready`.
  - The arbiter samples payload only in IDLE.
  - A master dropping `valid` mid-transaction does not abort it; the controller access completes and `ready` still pulses.
- Reset (synchronous, any state, including mid-BUSY):
  - State IDLE; `s_valid`, `mX_ready`, `mX_fault` = 0; `s_addr`, `s_wdata`, `s_wstrb`, `s_psram`, `mX_rdata` = 0.
  - Last-grant pointer = m1, so m0 wins the first tie.
  - The controller is reset by the same `resetn`.

## Timing
- Request present in IDLE at edge k: `s_valid`=1 from k+1.
- `s_ready` sampled at edge r: `mX_ready` high during cycle r+1 only; IDLE at r+2.
- Minimum master-to-master turnaround: 1 IDLE cycle after RESP.
- Fault latency: request at edge k, `mX_ready`+`mX_fault` high in cycle k+1, IDLE at k+2.
- All outputs are registered; no combinational path from `mX_*` or `s_ready` to any output.
- Back-to-back requests from both masters alternate strictly (m0, m1, m0, …), so neither starves.

## Test plan
- **Reset:** assert `resetn=0` mid-BUSY (`s_valid`=1) → next cycle all outputs 0, state IDLE; first tie after release grants m0.
- **PSRAM write:** m0 writes 0x8000_0010, data 0xDEADBEEF, strobes 4'hF → `s_valid`=1 one cycle later with `s_addr`=23'h4, `s_psram`=1. Controller `s_ready` at r → `m0_ready` pulse at r+1, `m0_fault`=0. Read back returns 0xDEADBEEF.
- **Tie round-robin:** both masters hold reads to 0x2000_0000 / 0x8000_0004 → grants m0, m1, m0, m1; `s_valid` low at least 1 cycle between accesses; each `mX_rdata` matches the model.
- **NOR write fault:** m1 writes 0x2000_0000 → `m1_ready`=`m1_fault`=1 the next cycle, `m1_rdata`=0, `s_valid` never asserted.
- **Out-of-range:** m0 reads 0x9000_0000 → fault pulse. Then m0 reads 0x2000_0004 → `s_psram`=0, `s_addr`=23'h1, normal completion.
- **Slow controller:** `s_ready` delayed 50 cycles while m1 asserts `valid` → `s_*` outputs stable throughout; m1 granted only after m0's RESP + IDLE.
